// File: rtl/bad_apple_pkg.sv
// Shared constants and types for the video/audio streaming path.
package bad_apple_pkg;

    // 320x240 at 1 bpp, MSB of each byte is the leftmost pixel.
    localparam int FRAME_BYTES  = 9600;
    localparam int ADDR_W       = 14;
    // Display vsyncs per source frame (30 fps source on a 60 Hz display).
    localparam int FRAME_REPEAT = 2;

    // Command bytes recognised by the SPI data FSM.
    localparam logic [7:0] VIDEO_CMD = 8'hFA;
    localparam logic [7:0] AUDIO_CMD = 8'hAA;

    // Identifies one of the two frame banks.
    typedef logic bank_t;

    // The bank the display side reads while the other is being written.
    function automatic bank_t other_bank(input bank_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/video_pingpong_buffer_if.sv
// Signal bundle between the SPI data FSM / display side and the frame store.
interface video_pingpong_buffer_if #(
    parameter int ADDR_W = bad_apple_pkg::ADDR_W
);
    logic              SPI_clock_enable;
    logic              MISO;
    logic              write_video;
    logic              video_bank_sel;
    logic              video_bank_full;
    logic              vsync_pulse;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_done;

    // Data FSM and display controller side.
    modport master (
        output SPI_clock_enable, MISO, write_video, video_bank_sel,
               vsync_pulse, rd_en, rd_addr,
        input  video_bank_full, rd_data, frame_done
    );

    // Frame store side.
    modport slave (
        input  SPI_clock_enable, MISO, write_video, video_bank_sel,
               vsync_pulse, rd_en, rd_addr,
        output video_bank_full, rd_data, frame_done
    );
endinterface

// File: rtl/video_bank_ram.sv
// One frame bank: simple dual-port byte RAM with a registered read port.
module video_bank_ram #(
    parameter int ADDR_W = 14
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // Read data holds its value unless a read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Write port; contents are deliberately not cleared by reset.
    always_ff @(posedge CLK_50) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register is cleared by reset so rd_data starts at zero.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/video_pingpong_buffer.sv
// Ping-pong 1-bpp frame store: deserialises MISO into the write bank while the
// display reads the other bank, and paces frame requests from display vsync.
module video_pingpong_buffer
    import bad_apple_pkg::*;
#(
    parameter int FRAME_BYTES  = bad_apple_pkg::FRAME_BYTES,
    parameter int ADDR_W       = bad_apple_pkg::ADDR_W,
    parameter int FRAME_REPEAT = bad_apple_pkg::FRAME_REPEAT
) (
    input  logic                   CLK_50,
    input  logic                   reset,
    video_pingpong_buffer_if.slave bus
);
    localparam int                VS_W      = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [VS_W-1:0]   VS_LAST   = VS_W'(FRAME_REPEAT - 1);

    logic [6:0]        shreg_q,       shreg_d;
    logic [2:0]        bit_cnt_q,     bit_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q,     wr_addr_d;
    logic              full_q,        full_d;
    bank_t             sel_q,         sel_d;
    logic [VS_W-1:0]   vsync_cnt_q,   vsync_cnt_d;
    logic              frame_done_q,  frame_done_d;
    bank_t             rd_bank_q,     rd_bank_d;
    logic              rd_oob_q,      rd_oob_d;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       swap;
    logic       vs_wrap;
    logic [7:0] ram_rdata [2];

    // Next-state logic for the write counters, frame pacing and read mux select.
    always_comb begin
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        wr_addr_d    = wr_addr_q;
        full_d       = full_q;
        sel_d        = bus.video_bank_sel;
        vsync_cnt_d  = vsync_cnt_q;
        frame_done_d = frame_done_q;
        rd_bank_d    = rd_bank_q;
        rd_oob_d     = rd_oob_q;
        wr_en        = 1'b0;
        wr_data      = {shreg_q, bus.MISO};
        swap         = (bus.video_bank_sel != sel_q);
        vs_wrap      = bus.vsync_pulse && (vsync_cnt_q == VS_LAST);

        if (bus.SPI_clock_enable) begin
            if (bus.write_video) begin
                // Once the bank is full, further bits are dropped: no wrap.
                if (!full_q) begin
                    shreg_d   = {shreg_q[5:0], bus.MISO};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        wr_en     = !reset;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        if (wr_addr_q == LAST_ADDR) begin
                            full_d = 1'b1;
                        end
                    end
                end
            end else begin
                // Payload paused mid-byte: discard the partial byte.
                shreg_d   = 7'd0;
                bit_cnt_d = 3'd0;
            end
        end

        // A bank toggle restarts filling; a byte completing on the same edge
        // still lands in the old bank because the write uses sel_q.
        if (swap) begin
            shreg_d   = 7'd0;
            bit_cnt_d = 3'd0;
            wr_addr_d = '0;
            full_d    = 1'b0;
        end

        if (bus.vsync_pulse) begin
            vsync_cnt_d = vs_wrap ? '0 : vsync_cnt_q + VS_W'(1);
        end

        // Request stays up through the next strobe so the FSM sees it once.
        if (vs_wrap) begin
            frame_done_d = 1'b1;
        end else if (bus.SPI_clock_enable) begin
            frame_done_d = 1'b0;
        end

        if (bus.rd_en) begin
            rd_bank_d = other_bank(bus.video_bank_sel);
            rd_oob_d  = (int'(bus.rd_addr) >= FRAME_BYTES);
        end
    end

    // State registers with synchronous reset; sel_q tracks the input so reset
    // never looks like a bank swap.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            shreg_q      <= 7'd0;
            bit_cnt_q    <= 3'd0;
            wr_addr_q    <= '0;
            full_q       <= 1'b0;
            sel_q        <= bus.video_bank_sel;
            vsync_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_oob_q     <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            wr_addr_q    <= wr_addr_d;
            full_q       <= full_d;
            sel_q        <= sel_d;
            vsync_cnt_q  <= vsync_cnt_d;
            frame_done_q <= frame_done_d;
            rd_bank_q    <= rd_bank_d;
            rd_oob_q     <= rd_oob_d;
        end
    end

    // Two identical banks; only the bank being written sees the write enable.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            video_bank_ram #(
                .ADDR_W (ADDR_W)
            ) u_ram (
                .CLK_50 (CLK_50),
                .reset  (reset),
                .we     (wr_en && (sel_q == bank_t'(gi))),
                .waddr  (wr_addr_q),
                .wdata  (wr_data),
                .re     (bus.rd_en),
                .raddr  (bus.rd_addr),
                .rdata  (ram_rdata[gi])
            );
        end
    endgenerate

    assign bus.video_bank_full = full_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.rd_data         = rd_oob_q ? 8'h00 : ram_rdata[rd_bank_q];
endmodule

// File: tb/tb_video_pingpong_buffer.sv
// Randomised bench for video_pingpong_buffer with a byte-level reference model.
module tb_video_pingpong_buffer;
    localparam int FB = 300;
    localparam int AW = 9;
    localparam int FR = 2;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    video_pingpong_buffer_if #(.ADDR_W(AW)) bus();

    video_pingpong_buffer #(
        .FRAME_BYTES  (FB),
        .ADDR_W       (AW),
        .FRAME_REPEAT (FR)
    ) dut (
        .CLK_50 (clk),
        .reset  (reset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0] m_mem   [2][FB];
    bit         m_known [2][FB];
    bit         m_bitq  [$];
    int         m_addr;
    bit         m_full;
    bit         m_sel;
    int         m_vs;
    bit         m_done;
    logic [7:0] m_rd;
    bit         m_rd_known;
    bit         rand_vs = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: update the model from the inputs applied this cycle,
    // then sample and compare the outputs just after the edge.
    task automatic tick();
        bit set_done;
        int v;
        set_done = 1'b0;
        if (reset) begin
            m_bitq.delete();
            m_addr     = 0;
            m_full     = 1'b0;
            m_sel      = bus.video_bank_sel;
            m_vs       = 0;
            m_done     = 1'b0;
            m_rd       = 8'h00;
            m_rd_known = 1'b1;
        end else begin
            if (bus.rd_en) begin
                if (int'(bus.rd_addr) >= FB) begin
                    m_rd       = 8'h00;
                    m_rd_known = 1'b1;
                end else begin
                    m_rd       = m_mem[!bus.video_bank_sel][bus.rd_addr];
                    m_rd_known = m_known[!bus.video_bank_sel][bus.rd_addr];
                end
            end
            if (bus.SPI_clock_enable) begin
                if (!bus.write_video) begin
                    m_bitq.delete();
                end else if (!m_full) begin
                    m_bitq.push_back(bus.MISO);
                    if (m_bitq.size() == 8) begin
                        v = 0;
                        for (int i = 0; i < 8; i++) v = v * 2 + int'(m_bitq[i]);
                        m_mem[m_sel][m_addr]   = v[7:0];
                        m_known[m_sel][m_addr] = 1'b1;
                        m_addr++;
                        if (m_addr == FB) m_full = 1'b1;
                        m_bitq.delete();
                    end
                end
            end
            if (bus.video_bank_sel != m_sel) begin
                m_sel  = bus.video_bank_sel;
                m_addr = 0;
                m_full = 1'b0;
                m_bitq.delete();
            end
            if (bus.vsync_pulse) begin
                m_vs++;
                if (m_vs == FR) begin
                    m_vs     = 0;
                    set_done = 1'b1;
                end
            end
            if (set_done) m_done = 1'b1;
            else if (bus.SPI_clock_enable) m_done = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val("full", bus.video_bank_full, m_full);
        check_val("frame_done", bus.frame_done, m_done);
        if (m_rd_known) check_val("rd_data", bus.rd_data, m_rd);
    endtask

    task automatic gap();
        if ($urandom_range(0, 3) == 0) begin
            bus.vsync_pulse = rand_vs && ($urandom_range(0, 7) == 0);
            tick();
            bus.vsync_pulse = 1'b0;
        end
    endtask

    task automatic send_bit(input bit b);
        bus.SPI_clock_enable = 1'b1;
        bus.write_video      = 1'b1;
        bus.MISO             = b;
        tick();
        bus.SPI_clock_enable = 1'b0;
        bus.MISO             = 1'b0;
        gap();
    endtask

    task automatic strobe_nowrite();
        bus.SPI_clock_enable = 1'b1;
        bus.write_video      = 1'b0;
        tick();
        bus.SPI_clock_enable = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        $display("byte  sel=%0d data=%02h model_addr=%0d full=%0d", m_sel, b, m_addr, m_full);
    endtask

    task automatic read(input int addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        tick();
        bus.rd_en   = 1'b0;
        bus.rd_addr = AW'($urandom);
        tick();
        $display("read  bank=%0d addr=%0d data=%02h", !bus.video_bank_sel, addr, bus.rd_data);
    endtask

    task automatic pulse_vsync();
        bus.vsync_pulse = 1'b1;
        tick();
        bus.vsync_pulse = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        reset                = 1'b1;
        bus.SPI_clock_enable = 1'b0;
        bus.MISO             = 1'b0;
        bus.write_video      = 1'b0;
        bus.video_bank_sel   = 1'b0;
        bus.vsync_pulse      = 1'b0;
        bus.rd_en            = 1'b0;
        bus.rd_addr          = '0;
        repeat (3) tick();
        check_val("rst_full", bus.video_bank_full, 0);
        check_val("rst_done", bus.frame_done, 0);
        check_val("rst_rd", bus.rd_data, 0);
        reset = 1'b0;
        tick();

        // First byte A5 at address 0, then a dropped partial and FF at address 1.
        for (int i = 7; i >= 0; i--) send_bit(a5[i]);
        check_val("a5_not_full", bus.video_bank_full, 0);
        repeat (5) send_bit(1'($urandom_range(0, 1)));
        strobe_nowrite();
        send_byte(8'hFF);

        // Fill the rest of bank 0 with byte i = i[7:0], then overflow.
        rand_vs = 1'b1;
        for (int a = 2; a < FB; a++) send_byte(8'(a));
        check_val("frame_full", bus.video_bank_full, 1);
        repeat (16) send_bit(1'($urandom_range(0, 1)));
        check_val("overflow_full", bus.video_bank_full, 1);
        rand_vs = 1'b0;

        // Swap: bank 0 becomes the read bank.
        bus.video_bank_sel = 1'b1;
        tick();
        check_val("swap_full_clr", bus.video_bank_full, 0);
        read(3);
        check_val("rd_addr3", bus.rd_data, 8'h03);
        read(0);
        check_val("rd_addr0_nowrap", bus.rd_data, 8'hA5);
        read(1);
        check_val("rd_addr1_ff", bus.rd_data, 8'hFF);
        read(FB - 1);
        read(FB);
        check_val("rd_oob", bus.rd_data, 8'h00);
        read(2**AW - 1);
        repeat (8) read(int'($urandom_range(0, 2**AW - 1)));

        // Reset after 3 bytes plus 4 bits into bank 1.
        repeat (3) send_byte(8'($urandom));
        repeat (4) send_bit(1'($urandom_range(0, 1)));
        reset = 1'b1;
        tick();
        check_val("mid_rst_full", bus.video_bank_full, 0);
        check_val("mid_rst_done", bus.frame_done, 0);
        check_val("mid_rst_rd", bus.rd_data, 0);
        reset = 1'b0;
        tick();
        send_byte(8'h5C);
        send_byte(8'h3E);
        bus.video_bank_sel = 1'b0;
        tick();
        read(0);
        check_val("post_rst_addr0", bus.rd_data, 8'h5C);
        read(1);
        check_val("post_rst_addr1", bus.rd_data, 8'h3E);

        // Frame pacing: one vsync gives nothing, the second raises frame_done.
        pulse_vsync();
        repeat (10) tick();
        check_val("one_vsync", bus.frame_done, 0);
        pulse_vsync();
        check_val("two_vsync", bus.frame_done, 1);
        repeat (40) tick();
        check_val("done_hold", bus.frame_done, 1);
        strobe_nowrite();
        check_val("done_clr", bus.frame_done, 0);
        // A period completing while a request is pending is not counted twice.
        pulse_vsync();
        pulse_vsync();
        repeat (3) tick();
        pulse_vsync();
        pulse_vsync();
        check_val("pending_set", bus.frame_done, 1);
        strobe_nowrite();
        check_val("pending_clr", bus.frame_done, 0);
        repeat (5) tick();

        // Mixed random traffic.
        rand_vs = 1'b1;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 5))
                0:       read(int'($urandom_range(0, FB + 20)));
                1:       begin bus.video_bank_sel = ~bus.video_bank_sel; tick(); end
                2:       begin repeat ($urandom_range(1, 6)) send_bit(1'($urandom_range(0, 1))); strobe_nowrite(); end
                default: send_byte(8'($urandom));
            endcase
        end
        rand_vs = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
